mem_arbiter: RTL
================

# mem_arbiter

Two-master arbiter for the native picorv32-style memory bus (valid/ready/addr/wdata/wstrb/rdata). It shares the single SoC memory/peripheral bus between the CPU (master 0) and a second bus master (master 1), such as the bootloader verifier or a future DMA engine. Arbitration between the masters is round-robin. A bus-timeout watchdog completes any transaction the addressed slave never acknowledges, so an unmapped address cannot hang a master.

## Interface
Parameters:
- TIMEOUT, 256: cycles a granted transaction may wait for `s_ready`; 0 disables the watchdog.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_valid, m1_valid  in  1  master request.
- m0_instr, m1_instr  in  1  instruction-fetch qualifier.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_wstrb, m1_wstrb  in  4  byte write strobes; 0 means read.
- m0_ready, m1_ready  out  1  transaction-complete strobe to the master.
- m0_rdata, m1_rdata  out  32  read data, valid while the matching ready is high.
- s_valid  out  1  request to the slave bus / address decoder.
- s_instr, s_addr, s_wdata, s_wstrb  out  1/32/32/4  forwarded from the granted master.
- s_ready  in  1  slave completion, combinational OR of slave readies.
- s_rdata  in  32  slave read data.
- grant  out  2  one-hot registered grant; 2'b00 when idle.
- timeout_err  out  1  one-cycle pulse when a transaction times out.
- err_addr  out  32  address of the most recent timed-out transaction.

## Operation
- Two states: IDLE and BUSY.
- IDLE:
  - `s_valid` = 0; `s_ready` is ignored.
  - If exactly one `mN_valid` is high, register a grant to that master and go to BUSY.
  - If both are high, grant the master that was not granted last.
  - `last` resets to 1, so m0 wins the first tie.
- BUSY:
  - `s_instr`, `s_addr`, `s_wdata` and `s_wstrb` are combinational muxes of the granted master's signals.
  - `s_valid` = granted `mN_valid`.
  - `mN_ready` = `s_ready`, and `mN_rdata` = `s_rdata`, for the granted master only.
  - On `s_ready`: the granted master gets its ready pulse, `last` <= granted index, `grant` <= 0, and the next state is IDLE.
- Non-granted master:
  - `mN_ready` = 0 and `mN_rdata` = 0 at all times.
  - Its request stays pending; masters must hold valid and payload stable until their ready.
- Granted master drops valid before ready (protocol violation):
  - Return to IDLE next cycle and produce no ready.
  - `last` is updated as if the transaction had completed.
- Watchdog, when TIMEOUT > 0:
  - Counter `cnt` is clog2(TIMEOUT+1) bits wide, cleared in IDLE, and increments each BUSY cycle without `s_ready`.
  - When `cnt` == TIMEOUT-1 and `s_ready` = 0, that cycle is the timeout completion:
    - force `s_valid` = 0;
    - assert the granted `mN_ready` with `mN_rdata` = ERR_DATA;
    - pulse `timeout_err`;
    - register `err_addr` <= granted address;
    - go to IDLE and update `last`.
- `s_ready` arriving in the same cycle the counter hits the limit counts as normal completion, with no error.
- Writes that time out complete silently; the master sees ready and only `timeout_err` flags the failure.
- Reset, whenever asserted (also mid-transaction), takes effect on the next edge:
  - state IDLE, `grant` 0, `last` 1, `cnt` 0, `timeout_err` 0, `err_addr` 0;
  - all `s_*` and `mN_ready`/`mN_rdata` outputs are 0 from that edge;
  - an in-flight transaction is dropped with no ready.

## Timing
- Arbitration latency is 1 cycle: `mN_valid` seen in IDLE at edge k gives `grant` and `s_valid` from cycle k+1.
- With a zero-wait slave (combinational `s_ready`), ready arrives in cycle k+1.
- Minimum transaction occupancy is 2 cycles: one IDLE cycle, then one BUSY cycle.
- Back-to-back requests from one master are separated by at least one IDLE cycle. This one-cycle bubble is the picorv32 valid-low gap.
- With TIMEOUT=N, the error ready arrives in the N-th BUSY cycle.
- `timeout_err` is coincident with that error ready.
- `err_addr` is valid from the following cycle.
- `grant` changes only at clock edges and is never 2'b11.

## Test plan
- Single master:
  - Stimulus: m0 reads 0x2000_0010; slave returns ready after 3 wait cycles with rdata 0x1234_5678.
  - Required: `grant`=01 from cycle 1; m0_ready in cycle 4 with 0x1234_5678; m1_ready never asserts.
- Contention round-robin:
  - Stimulus: m0 and m1 both assert valid continuously with a 1-cycle slave.
  - Required: grants alternate 01,10,01,10; m0 wins the first grant after reset; no master is starved.
- Timeout, TIMEOUT=8:
  - Stimulus: m1 reads unmapped 0x5000_0000 and the slave never responds.
  - Required: m1_ready with 0xDEAD_BEEF in the 8th BUSY cycle; `timeout_err` pulses 1 cycle; `err_addr`=0x5000_0000; `s_valid` is 0 in that cycle.
- Ready at the limit:
  - Stimulus: `s_ready` arrives exactly in BUSY cycle 8 with TIMEOUT=8.
  - Required: normal slave data is returned and there is no `timeout_err`.
- Reset mid-transaction:
  - Stimulus: assert reset in BUSY cycle 2 of a write.
  - Required: next cycle `grant`=00 and `s_valid`=0; no ready; after release, a pending m1 request is granted after m0's tie-break, with `last` reset.
- Valid drop:
  - Stimulus: m0 deasserts valid while granted.
  - Required: IDLE next cycle; no m0_ready; a pending m1 request is granted the cycle after.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the picorv32 native memory bus, with a
// bus-timeout watchdog that completes transactions no slave acknowledges.
module mem_arbiter #(
  parameter int          TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err,
  output logic [31:0] err_addr
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit WD_EN = (TIMEOUT > 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   err_addr_q, err_addr_d;

  logic          busy, gidx;
  logic          sel_valid, sel_instr;
  logic [31:0]   sel_addr, sel_wdata;
  logic [3:0]    sel_wstrb;
  logic          done_ok, to_hit, drop, rdy, pick;
  logic [31:0]   rsp_data;

  // grant_q is one-hot, so bit 1 alone identifies the owner
  always_comb begin
    busy      = (state_q == BUSY);
    gidx      = grant_q[1];
    sel_valid = gidx ? m1_valid : m0_valid;
    sel_instr = gidx ? m1_instr : m0_instr;
    sel_addr  = gidx ? m1_addr  : m0_addr;
    sel_wdata = gidx ? m1_wdata : m0_wdata;
    sel_wstrb = gidx ? m1_wstrb : m0_wstrb;

    drop     = busy && !sel_valid;
    done_ok  = busy && sel_valid && s_ready;
    to_hit   = WD_EN && busy && sel_valid && !s_ready && (cnt_q == CNT_LIM);
    rdy      = done_ok || to_hit;
    rsp_data = to_hit ? ERR_DATA : s_rdata;
  end

  always_comb begin
    s_valid     = busy && sel_valid && !to_hit;
    s_instr     = busy ? sel_instr : 1'b0;
    s_addr      = busy ? sel_addr  : 32'h0;
    s_wdata     = busy ? sel_wdata : 32'h0;
    s_wstrb     = busy ? sel_wstrb : 4'h0;
    m0_ready    = rdy && !gidx;
    m1_ready    = rdy && gidx;
    m0_rdata    = (busy && !gidx) ? rsp_data : 32'h0;
    m1_rdata    = (busy && gidx)  ? rsp_data : 32'h0;
    timeout_err = to_hit;
    grant       = grant_q;
    err_addr    = err_addr_q;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    err_addr_d = err_addr_q;
    pick       = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m0_valid || m1_valid) begin
          // on a tie, favour whichever master was not served last
          pick    = (m0_valid && m1_valid) ? !last_q : m1_valid;
          grant_d = pick ? 2'b10 : 2'b01;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (drop || rdy) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = gidx;
          cnt_d   = '0;
          if (to_hit && !drop) err_addr_d = sel_addr;
        end else if (WD_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 2'b00;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      err_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule
